alu_multicycle: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_comb.sv | 50 +++++
 rtl/alu_multicycle.sv | 104 ++++++++++
 tb/tb_alu_multicycle.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op-code and FSM encodings for the multicycle ALU and its
// combinational slice.
package alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_NOR = 3'b100;
   localparam logic [2:0] OP_RSV = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/alu_comb.sv
// Combinational WIDTH-bit logic/arith slice: AND/OR/NOR/ADD/SUB/SLT with
// carry and signed overflow. MUL and the reserved op produce all zeros.
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_cout,
   output logic             o_ovf
);

   logic             w_sub;
   logic [WIDTH-1:0] w_bx;
   logic [WIDTH:0]   w_sum;
   logic             w_ovf;

   // SUB and SLT share the adder as A + ~B + 1; COUT is then not-borrow.
   assign w_sub = (i_op == OP_SUB) || (i_op == OP_SLT);
   assign w_bx  = w_sub ? ~i_b : i_b;
   assign w_sum = {1'b0, i_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
   assign w_ovf = (i_a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

   always_comb begin
      o_result = '0;
      o_cout   = 1'b0;
      o_ovf    = 1'b0;
      case (i_op)
         OP_AND: o_result = i_a & i_b;
         OP_OR:  o_result = i_a | i_b;
         OP_NOR: o_result = ~(i_a | i_b);
         OP_ADD, OP_SUB: begin
            o_result = w_sum[WIDTH-1:0];
            o_cout   = w_sum[WIDTH];
            o_ovf    = w_ovf;
         end
         OP_SLT: begin
            // sign XOR overflow keeps the comparison right when A-B overflows
            o_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
            o_cout   = w_sum[WIDTH];
            o_ovf    = w_ovf;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with Start/Busy/Done handshake: single-cycle ops finish in
// one clock, MUL runs an iterative shift-add over WIDTH clocks.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             Start,
   input  logic [2:0]       Operation,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             COUT,
   output logic             Overflow
);

   logic [0:0]         r_state;
   logic [CNTW-1:0]    r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mcand;
   logic               r_done;
   logic [WIDTH-1:0]   r_result;
   logic               r_cout;
   logic               r_ovf;

   logic [WIDTH-1:0]   w_res;
   logic               w_cout;
   logic               w_ovf;
   logic [WIDTH:0]     w_pp;
   logic [2*WIDTH-1:0] w_acc_nxt;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .i_op     (Operation),
      .i_a      (A),
      .i_b      (B),
      .o_result (w_res),
      .o_cout   (w_cout),
      .o_ovf    (w_ovf)
   );

   // Accumulator holds {partial product, remaining multiplier}; each step adds
   // the multiplicand to the high half when the multiplier LSB is set, then
   // shifts the whole thing right, the carry landing in the top bit.
   assign w_pp      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mcand : '0)};
   assign w_acc_nxt = {w_pp, r_acc[WIDTH-1:1]};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (Start) begin
                  if (Operation == OP_MUL) begin
                     r_mcand <= A;
                     r_acc   <= {{WIDTH{1'b0}}, B};
                     r_cnt   <= CNTW'(WIDTH);
                     r_state <= ST_RUN;
                  end else begin
                     r_result <= w_res;
                     r_cout   <= w_cout;
                     r_ovf    <= w_ovf;
                     r_done   <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               r_acc <= w_acc_nxt;
               r_cnt <= r_cnt - CNTW'(1);
               if (r_cnt == CNTW'(1)) begin
                  r_result <= w_acc_nxt[WIDTH-1:0];
                  r_ovf    <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                  r_cout   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign Busy     = (r_state == ST_RUN);
   assign Done     = r_done;
   assign Result   = r_result;
   assign Zero     = (r_result == '0);
   assign COUT     = r_cout;
   assign Overflow = r_ovf;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: a reference model queues the expected
// result per accepted request and a monitor checks it on every Done.
module tb_alu_multicycle;
   import alu_pkg::*;

   localparam int W = 24;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          Start = 1'b0;
   logic [2:0]    Operation = 3'b000;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic          Busy, Done, Zero, COUT, Overflow;
   logic [W-1:0]  Result;

   typedef struct {
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_done = 0;

   alu_multicycle #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .Start     (Start),
      .Operation (Operation),
      .A         (A),
      .B         (B),
      .Busy      (Busy),
      .Done      (Done),
      .Result    (Result),
      .Zero      (Zero),
      .COUT      (COUT),
      .Overflow  (Overflow)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference built on signed/unsigned integer arithmetic, not on the adder.
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint sa, sb, ua, ub, s, u;
      longint lo, hi;
      e  = '{res: '0, cout: 1'b0, ovf: 1'b0};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      lo = -(64'sd1 <<< (W-1));
      hi = (64'sd1 <<< (W-1)) - 1;
      case (op)
         OP_AND: e.res = a & b;
         OP_OR:  e.res = a | b;
         OP_NOR: e.res = ~(a | b);
         OP_ADD: begin
            u = ua + ub;
            s = sa + sb;
            e.res  = u[W-1:0];
            e.cout = (u >>> W) != 0;
            e.ovf  = (s > hi) || (s < lo);
         end
         OP_SUB, OP_SLT: begin
            u = ua - ub;
            s = sa - sb;
            e.res  = (op == OP_SUB) ? u[W-1:0] : ((sa < sb) ? W'(1) : W'(0));
            e.cout = (ua >= ub);
            e.ovf  = (s > hi) || (s < lo);
         end
         OP_MUL: begin
            u = ua * ub;
            e.res = u[W-1:0];
            e.ovf = (u >>> W) != 0;
         end
         default: ;
      endcase
      return e;
   endfunction

   always @(posedge CLK) begin
      #2;
      if (Done) begin
         n_done++;
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'(Done), 32'(0));
         end else begin
            mon_e = sb_q.pop_front();
            chk("result",   32'(Result),   32'(mon_e.res));
            chk("zero",     32'(Zero),     32'(mon_e.res == '0));
            chk("cout",     32'(COUT),     32'(mon_e.cout));
            chk("overflow", 32'(Overflow), 32'(mon_e.ovf));
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      Operation = op;
      A         = a;
      B         = b;
      Start     = 1'b1;
      if (push) sb_q.push_back(model(op, a, b));
   endtask

   // Called at a negedge; returns at the negedge where Done is seen.
   task automatic wait_done(output int lat, output int nbusy);
      bit found;
      found = 1'b0;
      lat   = 0;
      nbusy = 0;
      for (int k = 1; k <= 60 && !found; k++) begin
         @(negedge CLK);
         if (k == 1) Start = 1'b0;
         if (Busy) nbusy++;
         if (Done) begin
            found = 1'b1;
            lat   = k;
         end
      end
      if (!found) chk("done_timeout", 32'(Done), 32'(1));
   endtask

   task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int lat, nbusy;
      send(op, a, b, 1'b1);
      wait_done(lat, nbusy);
      chk("latency", 32'(lat),   (op == OP_MUL) ? 32'(W + 1) : 32'(1));
      chk("busy",    32'(nbusy), (op == OP_MUL) ? 32'(W)     : 32'(0));
   endtask

   initial begin
      int lat, nbusy, done_snap;
      logic [2:0] rop;

      repeat (2) @(negedge CLK);
      chk("rst_busy", 32'(Busy),     32'(0));
      chk("rst_done", 32'(Done),     32'(0));
      chk("rst_res",  32'(Result),   32'(0));
      chk("rst_zero", 32'(Zero),     32'(1));
      chk("rst_cout", 32'(COUT),     32'(0));
      chk("rst_ovf",  32'(Overflow), 32'(0));
      RST_N = 1'b1;
      @(negedge CLK);

      run(OP_ADD, 24'h7FFFFF, 24'h000001);
      chk("add_res",  32'(Result),   32'h800000);
      chk("add_ovf",  32'(Overflow), 32'(1));
      chk("add_cout", 32'(COUT),     32'(0));
      chk("add_zero", 32'(Zero),     32'(0));
      run(OP_SUB, 24'd5, 24'd5);
      chk("sub_zero", 32'(Zero), 32'(1));
      chk("sub_cout", 32'(COUT), 32'(1));
      run(OP_SLT, 24'hFFFFFF, 24'h000001);
      chk("slt_neg", 32'(Result), 32'(1));
      run(OP_SLT, 24'h800000, 24'h7FFFFF);
      chk("slt_ovf_res", 32'(Result),   32'(1));
      chk("slt_ovf",     32'(Overflow), 32'(1));
      run(OP_NOR, 24'h0, 24'h0);
      chk("nor_res", 32'(Result), 32'hFFFFFF);
      run(OP_AND, 24'hF0F0F0, 24'hFF00FF);
      chk("and_res", 32'(Result), 32'hF000F0);
      run(OP_OR, 24'hF0F0F0, 24'hFF00FF);
      chk("or_res", 32'(Result), 32'hFFF0FF);
      run(OP_RSV, 24'h123456, 24'h654321);
      chk("rsv_zero", 32'(Zero), 32'(1));
      run(OP_MUL, 24'd1000, 24'd3000);
      chk("mul_res", 32'(Result),   32'h2DC6C0);
      chk("mul_ovf", 32'(Overflow), 32'(0));
      run(OP_MUL, 24'h001000, 24'h001000);
      chk("mul_wrap_zero", 32'(Zero),     32'(1));
      chk("mul_wrap_ovf",  32'(Overflow), 32'(1));

      for (int i = 0; i < 10; i++) begin
         rop = 3'($urandom_range(0, 7));
         run(rop, W'($urandom), W'($urandom));
      end

      // Start while busy must be ignored; Start in the Done cycle accepted.
      send(OP_MUL, 24'd7, 24'd9, 1'b1);
      repeat (4) begin
         @(negedge CLK);
         Start = 1'b0;
      end
      send(OP_ADD, 24'd1, 24'd1, 1'b0);
      chk("busy_when_ignored", 32'(Busy), 32'(1));
      wait_done(lat, nbusy);
      chk("mul_ign_lat", 32'(lat),    32'(W + 1 - 4));
      chk("mul_ign_res", 32'(Result), 32'd63);
      send(OP_ADD, 24'd2, 24'd2, 1'b1);
      wait_done(lat, nbusy);
      chk("b2b_lat", 32'(lat),    32'(1));
      chk("b2b_res", 32'(Result), 32'd4);

      // Asynchronous reset aborts a running multiply.
      send(OP_MUL, 24'd123, 24'd456, 1'b1);
      repeat (10) begin
         @(negedge CLK);
         Start = 1'b0;
      end
      #2;
      RST_N = 1'b0;
      #1;
      chk("abort_busy", 32'(Busy),     32'(0));
      chk("abort_done", 32'(Done),     32'(0));
      chk("abort_res",  32'(Result),   32'(0));
      chk("abort_zero", 32'(Zero),     32'(1));
      chk("abort_cout", 32'(COUT),     32'(0));
      chk("abort_ovf",  32'(Overflow), 32'(0));
      sb_q.delete();
      done_snap = n_done;
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (W + 8) @(negedge CLK);
      chk("abort_no_done", 32'(n_done), 32'(done_snap));
      chk("abort_res_hold", 32'(Result), 32'(0));
      chk("sb_empty", 32'(sb_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
